// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: splits a 4:1 time-multiplexed sample stream back into four
// registered channel outputs. A two-state framer (HUNT / LOCKED) aligns on the
// sof-tagged channel-0 sample, then steps through channels 1..3. Framing
// violations raise a one-cycle sync_err pulse.
// Optional build macro SYNC_ERR_COUNT_EN adds err_cnt, an 8-bit saturating
// count of sync_err pulses.
module tdm_demux_1_4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             vld0,
  output logic             vld1,
  output logic             vld2,
  output logic             vld3,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
`ifdef SYNC_ERR_COUNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One-hot valid vector for a channel write.
  function automatic logic [3:0] ch_onehot(input logic en, input logic [1:0] ch);
    logic [3:0] v;
    v = 4'b0000;
    if (en) v[ch] = 1'b1;
    return v;
  endfunction

  // Increment that holds at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  state_t           state, state_nxt;
  logic [1:0]       sel_p1, sel_nxt;

  // Decoded action for the sample presented this cycle.
  logic             wr_en_p0;
  logic [1:0]       wr_ch_p0;
  logic             fd_p0;
  logic             se_p0;

  // Registered outputs.
  logic [WIDTH-1:0] o_p1 [4];
  logic [3:0]       vld_p1;
  logic             fd_p1;
  logic             se_p1;

  // State register: framer state and next-channel pointer advance only on valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      sel_p1 <= 2'd0;
    end else if (din_valid) begin
      state  <= state_nxt;
      sel_p1 <= sel_nxt;
    end
  end

  // Next-state logic: sof always realigns to channel 0; a missing sof at a frame start drops lock.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_p1;
    case (state)
      HUNT: begin
        if (sof) begin
          state_nxt = LOCKED;
          sel_nxt   = 2'd1;
        end
      end
      LOCKED: begin
        if (sof) begin
          sel_nxt = 2'd1;
        end else if (sel_p1 == 2'd0) begin
          state_nxt = HUNT;
          sel_nxt   = 2'd0;
        end else begin
          sel_nxt = sel_p1 + 2'd1;
        end
      end
      default: begin
        state_nxt = HUNT;
        sel_nxt   = 2'd0;
      end
    endcase
  end

  // Output decode: which channel (if any) takes din, and which pulses fire.
  always_comb begin
    wr_en_p0 = 1'b0;
    wr_ch_p0 = 2'd0;
    fd_p0    = 1'b0;
    se_p0    = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sof) begin
            wr_en_p0 = 1'b1;
            wr_ch_p0 = 2'd0;
          end
        end
        LOCKED: begin
          if (sof) begin
            // sof mid-frame is an early frame: flag it but still realign on it.
            wr_en_p0 = 1'b1;
            wr_ch_p0 = 2'd0;
            se_p0    = (sel_p1 != 2'd0);
          end else if (sel_p1 == 2'd0) begin
            se_p0    = 1'b1;
          end else begin
            wr_en_p0 = 1'b1;
            wr_ch_p0 = sel_p1;
            fd_p0    = (sel_p1 == 2'd3);
          end
        end
        default: begin
          wr_en_p0 = 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: register channel data and one-cycle pulses ----
  // Output registers: capture din into the selected channel and emit the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) o_p1[i] <= '0;
      vld_p1 <= 4'b0000;
      fd_p1  <= 1'b0;
      se_p1  <= 1'b0;
    end else begin
      vld_p1 <= ch_onehot(wr_en_p0, wr_ch_p0);
      fd_p1  <= fd_p0;
      se_p1  <= se_p0;
      if (wr_en_p0) o_p1[wr_ch_p0] <= din;
    end
  end

`ifdef SYNC_ERR_COUNT_EN
  logic [7:0] err_cnt_p1;

  // Error counter: counts framing violations together with the sync_err pulse, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_p1 <= 8'd0;
    end else if (se_p0) begin
      err_cnt_p1 <= sat_inc8(err_cnt_p1);
    end
  end

  assign err_cnt = err_cnt_p1;
`endif

  assign o0         = o_p1[0];
  assign o1         = o_p1[1];
  assign o2         = o_p1[2];
  assign o3         = o_p1[3];
  assign vld0       = vld_p1[0];
  assign vld1       = vld_p1[1];
  assign vld2       = vld_p1[2];
  assign vld3       = vld_p1[3];
  assign sel        = sel_p1;
  assign locked     = (state == LOCKED);
  assign frame_done = fd_p1;
  assign sync_err   = se_p1;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Bench for tdm_demux_1_4: directed frames, framing errors, gaps and resets,
// followed by a pseudo-random stream, all checked against a reference model.
module tb_tdm_demux_1_4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] o0, o1, o2, o3;
  logic         vld0, vld1, vld2, vld3;
  logic [1:0]   sel;
  logic         locked, frame_done, sync_err;
`ifdef SYNC_ERR_COUNT_EN
  logic [7:0]   err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tdm_demux_1_4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .o0         (o0),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .vld0       (vld0),
    .vld1       (vld1),
    .vld2       (vld2),
    .vld3       (vld3),
    .sel        (sel),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err)
`ifdef SYNC_ERR_COUNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0]        vld;
    logic              fd;
    logic              se;
    logic              lck;
    logic [1:0]        sel;
    logic [3:0][W-1:0] o;
    logic [7:0]        ec;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic              m_locked = 1'b0;
  logic [1:0]        m_sel    = 2'd0;
  logic [3:0][W-1:0] m_o      = '0;
  logic [7:0]        m_ec     = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its effect, then compare the registered outputs.
  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    exp_t e;
    e.vld = 4'b0000;
    e.fd  = 1'b0;
    e.se  = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_sel    = 2'd0;
      m_o      = '0;
      m_ec     = 8'd0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_o[0] = d; e.vld = 4'b0001; m_sel = 2'd1; m_locked = 1'b1;
        end
      end else if (s) begin
        e.se = (m_sel != 2'd0);
        m_o[0] = d; e.vld = 4'b0001; m_sel = 2'd1;
      end else if (m_sel == 2'd0) begin
        e.se = 1'b1; m_locked = 1'b0;
      end else begin
        m_o[m_sel] = d;
        e.vld = 4'b0001 << m_sel;
        e.fd  = (m_sel == 2'd3);
        m_sel = m_sel + 2'd1;
      end
      if (e.se && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    end
    e.lck = m_locked;
    e.sel = m_sel;
    e.o   = m_o;
    e.ec  = m_ec;
    sb.push_back(e);

    rst = r; din_valid = v; sof = s; din = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("vld",        {vld3, vld2, vld1, vld0}, e.vld);
    check("frame_done", frame_done, e.fd);
    check("sync_err",   sync_err, e.se);
    check("locked",     locked, e.lck);
    check("sel",        sel, e.sel);
    check("o0",         o0, e.o[0]);
    check("o1",         o1, e.o[1]);
    check("o2",         o2, e.o[2]);
    check("o3",         o3, e.o[3]);
    check("vld_onehot0", $onehot0({vld3, vld2, vld1, vld0}), 1'b1);
`ifdef SYNC_ERR_COUNT_EN
    check("err_cnt",    err_cnt, e.ec);
`endif
    rst = 1'b0; din_valid = 1'b0; sof = 1'b0;
  endtask

  initial begin
    // Reset.
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'hE7);
    check("rst_locked", locked, 1'b0);
    check("rst_sel", sel, 2'd0);
    check("rst_o0", o0, 8'h00);

    // Normal frame.
    step(0, 1, 1, 8'h11);
    check("nf_vld0", vld0, 1'b1);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h44);
    check("nf_fd", frame_done, 1'b1);
    check("nf_vld3", vld3, 1'b1);
    check("nf_o", {o0, o1, o2, o3}, 32'h11223344);
    check("nf_sel", sel, 2'd0);

    // Missing sof after a full frame.
    step(0, 1, 0, 8'h66);
    check("ms_se", sync_err, 1'b1);
    check("ms_locked", locked, 1'b0);
    check("ms_o0", o0, 8'h11);

    // Hunt discard.
    step(0, 1, 0, 8'hAA);
    check("hd_se_a", sync_err, 1'b0);
    step(0, 1, 0, 8'hBB);
    check("hd_o0_b", o0, 8'h11);
    step(0, 1, 1, 8'hCC);
    check("hd_o0", o0, 8'hCC);
    check("hd_locked", locked, 1'b1);
    check("hd_sel", sel, 2'd1);

    // Early sof at sel=2.
    step(0, 1, 0, 8'h77);
    check("es_sel2", sel, 2'd2);
    step(0, 1, 1, 8'h55);
    check("es_se", sync_err, 1'b1);
    check("es_o0", o0, 8'h55);
    check("es_sel", sel, 2'd1);
    check("es_fd", frame_done, 1'b0);
    check("es_o23", {o2, o3}, 16'h3344);

    // Gaps between samples.
    step(0, 0, 1, 8'hF0);
    step(0, 0, 0, 8'hF1);
    step(0, 1, 0, 8'h01);
    step(0, 0, 0, 8'hF2);
    check("gap_o1", o1, 8'h01);
    check("gap_vld1", vld1, 1'b0);
    check("gap_sel", sel, 2'd2);

    // Reset mid-frame with a coincident valid sample.
    step(1, 1, 0, 8'h99);
    check("mr_o", {o0, o1, o2, o3}, 32'h0);
    check("mr_locked", locked, 1'b0);
    check("mr_sel", sel, 2'd0);

    // Pseudo-random stream.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), W'($urandom));
    end

`ifdef SYNC_ERR_COUNT_EN
    // Saturating error count: repeated sof while locked is an early frame each time.
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h10);
    step(0, 1, 0, 8'h20);
    for (int i = 0; i < 300; i++) step(0, 1, 1, W'(i));
    check("err_cnt_sat", err_cnt, 8'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_4.md
TDM_DEMUX_1_4 -- requirements
Module: tdm_demux_1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits for din and o0..o3.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port din  input  WIDTH  time-multiplexed sample stream from the 4:1 channel mux.
REQ-005 SHALL have port din_valid  input  1  din carries a sample this cycle.
REQ-006 SHALL have port sof  input  1  start of frame; qualified by din_valid; marks the channel-0 sample.
REQ-007 SHALL have ports o0, o1, o2, o3  output  WIDTH each  registered per-channel samples, held until overwritten.
REQ-008 SHALL have ports vld0, vld1, vld2, vld3  output  1 each  one-cycle pulse when the matching oN is updated.
REQ-009 SHALL have port sel  output  2  channel index the next accepted sample is written to.
REQ-010 SHALL have port locked  output  1  high in state LOCKED.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when channel 3 is written.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 SHALL implement a two-state FSM: HUNT and LOCKED.
REQ-014 SHALL ignore every cycle with din_valid=0: no state, sel or output change; all pulses low.
REQ-015 In HUNT, din_valid=1 with sof=0 SHALL be discarded without raising sync_err.
REQ-016 In HUNT, din_valid=1 with sof=1 SHALL write din to o0, pulse vld0, set sel=1, and enter LOCKED.
REQ-017 In LOCKED with sel!=0, a valid sample with sof=0 SHALL write o[sel], pulse vld[sel], and advance sel by 1 modulo 4 (3 wraps to 0).
REQ-018 Writing channel 3 SHALL pulse frame_done in the same cycle as vld3.
REQ-019 In LOCKED with sel=0, a valid sample with sof=1 SHALL write o0, pulse vld0, and set sel=1.
REQ-020 In LOCKED with sel=0, a valid sample with sof=0 SHALL be discarded, pulse sync_err, set sel=0, and return to HUNT.
REQ-021 In LOCKED with sel!=0, a valid sample with sof=1 (early frame) SHALL pulse sync_err, write din to o0, pulse vld0, set sel=1, and stay LOCKED; frame_done SHALL NOT pulse.
REQ-022 All outputs SHALL be registered; an accepted sample SHALL appear on oN, with vldN high, in the cycle after the capturing clock edge (latency 1).
REQ-023 At most one vldN SHALL be high in any cycle.

Reset
REQ-024 rst=1 at a clock edge SHALL force HUNT, sel=0, o0..o3=0, and all vldN, frame_done, sync_err and locked to 0.
REQ-025 rst SHALL take priority over a coincident valid sample; that sample SHALL be discarded.
REQ-026 Reset asserted mid-frame SHALL abandon the partial frame; channels already written SHALL be cleared to 0.

Configuration
REQ-027 When macro SYNC_ERR_COUNT_EN is defined, the block SHALL add port err_cnt  output  8, an 8-bit saturating count of sync_err pulses.
REQ-028 err_cnt SHALL reset to 0, SHALL increment on each sync_err pulse, and SHALL hold at 255.
REQ-029 When SYNC_ERR_COUNT_EN is undefined, err_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Normal frame: after reset, send valid samples 0x11(sof), 0x22, 0x33, 0x44 -> o0..o3=0x11,0x22,0x33,0x44; vld0..vld3 pulse in order; frame_done pulses with vld3; sel ends at 0.
REQ-031 Hunt discard: send 0xAA and 0xBB without sof, then 0xCC with sof -> first two samples ignored, sync_err stays 0, o0=0xCC, locked=1, sel=1.
REQ-032 Early sof: locked with sel=2, send 0x55 with sof -> sync_err pulses, o0=0x55, sel=1, frame_done stays 0, o2 and o3 unchanged.
REQ-033 Missing sof: after a full frame, send 0x66 without sof -> sample discarded, sync_err pulses, locked=0, o0 unchanged.
REQ-034 Gaps and reset: insert din_valid=0 cycles between samples -> no output change during gaps; assert rst with sel=2 -> all outputs 0, HUNT; with SYNC_ERR_COUNT_EN, 300 errors -> err_cnt=255.
